video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Video source for bench and bring-up. It generates the raster timing (hsync, vsync, blank) and an 8-bit RGB test pattern that feed the pixel pipeline's video input. It is the transmitting end of the same video interface that the pipeline receives. It replaces the HDMI receiver when no source is attached. Pattern 3 encodes a per-frame counter, so pass-through mode sees a top-left pixel change on every frame.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line; must be a multiple of 8
- H_FP, 110, horizontal front porch (cycles)
- H_SYNC, 40, hsync width (cycles)
- H_BP, 220, horizontal back porch (cycles)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- clk  in  1  pixel clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- run  in  1  start/stop request; sampled as described under Operation
- pat  in  2  pattern select; sampled only at frame start
- out_red, out_green, out_blue  out  8 each  pixel data
- out_hsync, out_vsync  out  1 each  sync outputs, polarity set by HS_POL/VS_POL
- out_blank  out  1  1 = outside the active area
- frame_start  out  1  one-cycle pulse, coincident with output of pixel (0,0)
- frm_cnt  out  8  completed-frame counter

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Line layout: active, then front porch, then sync, then back porch. Frame layout uses the same order.
- FSM has two states, IDLE and RUN; reset enters IDLE.
- IDLE:
  - hc = vc = 0.
  - Outputs: blank = 1, syncs inactive, RGB = 0, frame_start = 0.
  - Go to RUN when run = 1.
- RUN:
  - hc increments every cycle. On hc = H_TOTAL-1 it wraps to 0 and vc increments.
  - On vc = V_TOTAL-1 with hc = H_TOTAL-1, vc wraps to 0, this is the end of frame, and frm_cnt increments (255 wraps to 0).
  - At end of frame, if run = 0, go to IDLE. Otherwise start the next frame at (0,0).
  - Deasserting run mid-frame is ignored; the frame always completes.
- Decoded outputs, as a function of (hc, vc):
  - blank = ~(hc < H_ACTIVE && vc < V_ACTIVE).
  - hsync active when H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
  - vsync active for whole lines V_ACTIVE+V_FP ≤ vc < V_ACTIVE+V_FP+V_SYNC. It changes only at hc = 0.
- Patterns: pat is latched into cur_pat when (hc,vc) = (0,0) is entered, and cur_pat holds for the whole frame. RGB = 0 whenever blank = 1.
  - 0: eight color bars, each H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black. Components are 0xFF or 0x00. The bar index comes from a sub-counter that resets at hc = 0, not from a divider.
  - 1: R = G = B = hc[7:0] (horizontal ramp).
  - 2: R = G = B = vc[7:0] (vertical ramp).
  - 3: R = G = B = frm_cnt (uniform frame-ID field).
- frm_cnt keeps its value across IDLE. Only rst clears it.

## Timing
- All outputs are registered, with one cycle of latency from position (hc,vc) to the outputs.
- Leaving IDLE:
  - Cycle n: IDLE with run = 1.
  - Cycle n+1: RUN, position (0,0).
  - Cycle n+2: outputs show pixel (0,0) and frame_start = 1.
- Frame period is exactly H_TOTAL×V_TOTAL cycles; there are no gap cycles between consecutive frames.
- frm_cnt updates on the same edge on which frame_start of the next frame is output, or the IDLE outputs if run = 0.
- Reset values:
  - State IDLE, hc = vc = 0, frm_cnt = 0, cur_pat = 0.
  - out_blank = 1, out_hsync = ~HS_POL, out_vsync = ~VS_POL, RGB = 0, frame_start = 0.
- Asserting rst mid-frame forces all reset values immediately (asynchronous) and discards the partial frame.

## Test plan
Small-raster parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, giving H_TOTAL = 14, V_TOTAL = 7 and a 98-cycle frame.

1. Reset then run=1, pat=1:
   - frame_start first rises exactly 2 cycles after run rises, then every 98 cycles.
   - Each active line shows RGB 0..7.
   - out_blank is low for exactly 32 cycles per frame.
2. Sync placement:
   - hsync high at hc 10–11 on all 7 lines.
   - vsync high for the full line vc = 5 (14 cycles), rising coincident with hc = 0 output.
   - Repeat with HS_POL = VS_POL = 0: waveforms are inverted.
3. pat=0:
   - Active pixels 0..7 read FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
   - Change pat to 3 mid-frame: no change until the next frame_start, after which every active pixel equals frm_cnt.
4. run drop:
   - Deassert run at hc = 3, vc = 1: the frame completes, frm_cnt increments by 1, then IDLE holds blank = 1 with syncs inactive.
   - Reassert run: the next frame_start comes 2 cycles later.
5. frm_cnt wrap: after 256 frames with pat=3, frm_cnt = 0 and the active pixels read 0x00.
6. Asynchronous rst mid-frame:
   - Assert rst between clock edges during the active area: outputs take reset values immediately.
   - frm_cnt = 0, and no frame_start occurs while rst is high.

Source files
------------

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing and test-pattern source for bench bring-up. It drives the
// same video interface the pixel pipeline receives from the HDMI receiver:
// hsync/vsync/blank plus 8-bit RGB. When no source is attached it stands in
// for the receiver.
//
// Patterns (selected by pat, latched at the start of every frame):
//   0: eight colour bars, white/yellow/cyan/green/magenta/red/blue/black
//   1: horizontal ramp, R = G = B = hc[7:0]
//   2: vertical ramp,   R = G = B = vc[7:0]
//   3: frame ID,        R = G = B = completed-frame counter
//
// Ports:
//   clk          pixel clock (single clock domain)
//   rst          asynchronous, active-high reset
//   run          start/stop request; stopping takes effect at end of frame
//   pat[1:0]     pattern select, sampled when position (0,0) is entered
//   out_red/out_green/out_blue[7:0]  pixel data, 0 while blanked
//   out_hsync, out_vsync             syncs, active level HS_POL / VS_POL
//   out_blank    1 outside the active area
//   frame_start  one-cycle pulse alongside pixel (0,0)
//   frm_cnt[7:0] completed-frame counter, wraps 255 -> 0
//
// All outputs are registered one cycle behind the (hc, vc) position.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] pat,
    output logic [7:0] out_red,
    output logic [7:0] out_green,
    output logic [7:0] out_blue,
    output logic       out_hsync,
    output logic       out_vsync,
    output logic       out_blank,
    output logic       frame_start,
    output logic [7:0] frm_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are at least 8 bits wide so the ramp patterns can always
    // take bits [7:0] directly, even on tiny test rasters.
    localparam int HC_W = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int VC_W = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;

    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG   = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG   = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    // Colour-bar sub-counter: r_bar_pix counts pixels inside one bar,
    // r_bar_idx selects the bar. Avoids a divide by H_ACTIVE/8.
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    localparam logic HS_ACT = 1'(HS_POL);
    localparam logic VS_ACT = 1'(VS_POL);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic            r_state;
    logic [HC_W-1:0] r_hc;
    logic [VC_W-1:0] r_vc;
    logic [BW-1:0]   r_bar_pix;
    logic [2:0]      r_bar_idx;
    logic [1:0]      r_cur_pat;
    logic [7:0]      r_frm_cnt;

    logic w_h_end;
    logic w_v_end;
    logic w_active;
    logic w_hs_on;
    logic w_vs_on;
    logic w_first;
    logic [7:0] w_red;
    logic [7:0] w_green;
    logic [7:0] w_blue;

    assign w_h_end  = (r_hc == H_LAST);
    assign w_v_end  = (r_vc == V_LAST);
    assign w_active = (r_hc < H_ACT_C) && (r_vc < V_ACT_C);
    assign w_hs_on  = (r_hc >= HS_BEG) && (r_hc < HS_END);
    // vc only changes on the hc wrap, so vsync naturally switches at hc = 0.
    assign w_vs_on  = (r_vc >= VS_BEG) && (r_vc < VS_END);
    assign w_first  = (r_hc == '0) && (r_vc == '0);

    // -------------------------------------------------------------------------
    // Position counters and run/idle control
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hc      <= '0;
            r_vc      <= '0;
            r_bar_pix <= '0;
            r_bar_idx <= '0;
            r_cur_pat <= '0;
            r_frm_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_hc      <= '0;
                    r_vc      <= '0;
                    r_bar_pix <= '0;
                    r_bar_idx <= '0;
                    if (run) begin
                        r_state   <= S_RUN;
                        r_cur_pat <= pat;
                    end
                end
                S_RUN: begin
                    if (w_h_end) begin
                        r_hc      <= '0;
                        r_bar_pix <= '0;
                        r_bar_idx <= '0;
                        if (w_v_end) begin
                            // End of frame: count it, then either restart at
                            // (0,0) with a freshly sampled pattern or stop.
                            r_vc      <= '0;
                            r_frm_cnt <= r_frm_cnt + 8'd1;
                            if (run) begin
                                r_cur_pat <= pat;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_vc <= r_vc + VC_W'(1);
                        end
                    end else begin
                        r_hc <= r_hc + HC_W'(1);
                        if (r_bar_pix == BAR_LAST) begin
                            r_bar_pix <= '0;
                            r_bar_idx <= r_bar_idx + 3'd1;
                        end else begin
                            r_bar_pix <= r_bar_pix + BW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Pattern generator (unblanked pixel value at the current position)
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_red   = 8'h00;
        w_green = 8'h00;
        w_blue  = 8'h00;
        case (r_cur_pat)
            2'd0: begin
                // Bar order W,Y,C,G,M,R,B,K maps to inverted index bits:
                // red off for idx[1], green off for idx[2], blue off for idx[0].
                w_red   = {8{~r_bar_idx[1]}};
                w_green = {8{~r_bar_idx[2]}};
                w_blue  = {8{~r_bar_idx[0]}};
            end
            2'd1: begin
                w_red   = r_hc[7:0];
                w_green = r_hc[7:0];
                w_blue  = r_hc[7:0];
            end
            2'd2: begin
                w_red   = r_vc[7:0];
                w_green = r_vc[7:0];
                w_blue  = r_vc[7:0];
            end
            default: begin
                w_red   = r_frm_cnt;
                w_green = r_frm_cnt;
                w_blue  = r_frm_cnt;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs, one cycle behind the position
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_blank   <= 1'b1;
            out_hsync   <= ~HS_ACT;
            out_vsync   <= ~VS_ACT;
            out_red     <= 8'h00;
            out_green   <= 8'h00;
            out_blue    <= 8'h00;
            frame_start <= 1'b0;
            frm_cnt     <= 8'h00;
        end else begin
            frm_cnt <= r_frm_cnt;
            if (r_state == S_RUN) begin
                out_blank   <= ~w_active;
                out_hsync   <= w_hs_on ? HS_ACT : ~HS_ACT;
                out_vsync   <= w_vs_on ? VS_ACT : ~VS_ACT;
                out_red     <= w_active ? w_red   : 8'h00;
                out_green   <= w_active ? w_green : 8'h00;
                out_blue    <= w_active ? w_blue  : 8'h00;
                frame_start <= w_first;
            end else begin
                out_blank   <= 1'b1;
                out_hsync   <= ~HS_ACT;
                out_vsync   <= ~VS_ACT;
                out_red     <= 8'h00;
                out_green   <= 8'h00;
                out_blue    <= 8'h00;
                frame_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Small raster: 8+2+2+2 = 14 cycles per line, 4+1+1+1 = 7 lines, 98-cycle
// frame. Two instances share the inputs: one with active-high syncs, one with
// active-low syncs. Expected output cycles are pushed to a queue as each
// scenario is set up and popped one per clock at the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_video_timing_gen;

    localparam int HT    = 14;
    localparam int VT    = 7;
    localparam int FRAME = HT * VT;

    logic       clk;
    logic       rst;
    logic       run;
    logic [1:0] pat;

    logic [7:0] out_red, out_green, out_blue, frm_cnt;
    logic       out_hsync, out_vsync, out_blank, frame_start;
    logic [7:0] n_red, n_green, n_blue, n_frm;
    logic       n_hsync, n_vsync, n_blank, n_fs;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .pat(pat),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_blank(out_blank),
        .frame_start(frame_start), .frm_cnt(frm_cnt)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0)
    ) dut_n (
        .clk(clk), .rst(rst), .run(run), .pat(pat),
        .out_red(n_red), .out_green(n_green), .out_blue(n_blue),
        .out_hsync(n_hsync), .out_vsync(n_vsync), .out_blank(n_blank),
        .frame_start(n_fs), .frm_cnt(n_frm)
    );

    typedef struct packed {
        logic       blank;
        logic       hs;
        logic       vs;
        logic       hs_n;
        logic       vs_n;
        logic       fs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] frm;
    } exp_t;

    exp_t exp_q[$];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_frm    = 8'h00;
    int         cnt_fs, cnt_blank_low, cnt_hs, cnt_vs, cnt_hs_n_low, cnt_vs_n_low;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    function automatic exp_t idle_e(input logic [7:0] fc);
        exp_t e;
        e       = '0;
        e.blank = 1'b1;
        e.hs_n  = 1'b1;
        e.vs_n  = 1'b1;
        e.frm   = fc;
        return e;
    endfunction

    function automatic exp_t pix_e(input int hc, input int vc, input int p, input logic [7:0] fc);
        exp_t        e;
        logic [23:0] rgb;
        e       = '0;
        e.blank = !(hc < 8 && vc < 4);
        e.hs    = (hc >= 10 && hc < 12);
        e.hs_n  = !e.hs;
        e.vs    = (vc == 5);
        e.vs_n  = !e.vs;
        e.fs    = (hc == 0 && vc == 0);
        e.frm   = fc;
        rgb     = 24'h000000;
        if (!e.blank) begin
            case (p)
                0: case (hc)
                       0: rgb = 24'hFFFFFF;
                       1: rgb = 24'hFFFF00;
                       2: rgb = 24'h00FFFF;
                       3: rgb = 24'h00FF00;
                       4: rgb = 24'hFF00FF;
                       5: rgb = 24'hFF0000;
                       6: rgb = 24'h0000FF;
                       default: rgb = 24'h000000;
                   endcase
                1: rgb = {3{8'(hc)}};
                2: rgb = {3{8'(vc)}};
                default: rgb = {3{fc}};
            endcase
        end
        {e.r, e.g, e.b} = rgb;
        return e;
    endfunction

    task automatic push_frame(input int p);
        for (int vc = 0; vc < VT; vc++)
            for (int hc = 0; hc < HT; hc++)
                exp_q.push_back(pix_e(hc, vc, p, m_frm));
        m_frm = m_frm + 8'd1;
    endtask

    // Pops one expected cycle per falling edge and compares both instances.
    task automatic sb_drain(input string tag);
        exp_t e;
        exp_t o;
        int   idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e      = exp_q.pop_front();
            o      = '0;
            o.blank = out_blank;
            o.hs    = out_hsync;
            o.vs    = out_vsync;
            o.hs_n  = n_hsync;
            o.vs_n  = n_vsync;
            o.fs    = frame_start;
            o.r     = out_red;
            o.g     = out_green;
            o.b     = out_blue;
            o.frm   = frm_cnt;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got blank/hs/vs/hs_n/vs_n/fs=%b%b%b%b%b%b rgb=%h%h%h frm=%h, want %b%b%b%b%b%b rgb=%h%h%h frm=%h",
                         tag, idx, o.blank, o.hs, o.vs, o.hs_n, o.vs_n, o.fs, o.r, o.g, o.b, o.frm,
                         e.blank, e.hs, e.vs, e.hs_n, e.vs_n, e.fs, e.r, e.g, e.b, e.frm);
            end
            n_checks++;
            if ({n_blank, n_fs, n_red, n_green, n_blue, n_frm} !== {e.blank, e.fs, e.r, e.g, e.b, e.frm}) begin
                n_fail++;
                $display("FAIL %s_neg cycle %0d: got blank=%b fs=%b rgb=%h%h%h frm=%h, want blank=%b fs=%b rgb=%h%h%h frm=%h",
                         tag, idx, n_blank, n_fs, n_red, n_green, n_blue, n_frm,
                         e.blank, e.fs, e.r, e.g, e.b, e.frm);
            end
            if (frame_start)  cnt_fs++;
            if (!out_blank)   cnt_blank_low++;
            if (out_hsync)    cnt_hs++;
            if (out_vsync)    cnt_vs++;
            if (!n_hsync)     cnt_hs_n_low++;
            if (!n_vsync)     cnt_vs_n_low++;
            idx++;
        end
    endtask

    // Starts from IDLE at a falling edge, runs nfr frames back to back,
    // switches pat to p1 partway through the first frame, and drops run at
    // (hc 3, vc 1) of the last frame so the generator returns to IDLE.
    task automatic play(input int nfr, input int p0, input int p1, input string tag);
        int drop_k;
        drop_k = (nfr - 1) * FRAME + 18;
        cnt_fs = 0; cnt_blank_low = 0; cnt_hs = 0; cnt_vs = 0;
        cnt_hs_n_low = 0; cnt_vs_n_low = 0;
        pat = 2'(p0);
        run = 1'b1;
        exp_q.push_back(idle_e(m_frm));
        for (int f = 0; f < nfr; f++) push_frame((f == 0) ? p0 : p1);
        exp_q.push_back(idle_e(m_frm));
        exp_q.push_back(idle_e(m_frm));
        fork
            begin
                repeat (50) @(negedge clk);
                pat = 2'(p1);
            end
            begin
                repeat (drop_k) @(negedge clk);
                run = 1'b0;
            end
            sb_drain(tag);
        join
    endtask

    // ---------------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; run = 1'b0; pat = 2'd0;
        #1;
        n_checks++;
        if ({out_blank, out_hsync, out_vsync, out_red, out_green, out_blue, frame_start, frm_cnt, n_hsync, n_vsync}
            !== {1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 8'h00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: got blank=%b hs=%b vs=%b rgb=%h%h%h fs=%b frm=%h hs_n=%b vs_n=%b, want 1 0 0 000000 0 00 1 1",
                     out_blank, out_hsync, out_vsync, out_red, out_green, out_blue, frame_start, frm_cnt, n_hsync, n_vsync);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({out_blank, out_hsync, out_vsync, frame_start, out_red} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL idle_hold: got blank=%b hs=%b vs=%b fs=%b red=%h, want 1 0 0 0 00",
                     out_blank, out_hsync, out_vsync, frame_start, out_red);
        end
    endtask

    task automatic test_ramp();
        play(2, 1, 1, "ramp");
        n_checks++;
        if (cnt_fs !== 2) begin
            n_fail++;
            $display("FAIL ramp_fs_count: got %0d want 2", cnt_fs);
        end
        n_checks++;
        if (cnt_blank_low !== 64) begin
            n_fail++;
            $display("FAIL ramp_active_cycles: got %0d want 64", cnt_blank_low);
        end
    endtask

    task automatic test_sync();
        play(1, 2, 2, "sync");
        n_checks++;
        if (cnt_hs !== 14 || cnt_hs_n_low !== 14) begin
            n_fail++;
            $display("FAIL hsync_cycles: got pos=%0d neg=%0d want 14 14", cnt_hs, cnt_hs_n_low);
        end
        n_checks++;
        if (cnt_vs !== 14 || cnt_vs_n_low !== 14) begin
            n_fail++;
            $display("FAIL vsync_cycles: got pos=%0d neg=%0d want 14 14", cnt_vs, cnt_vs_n_low);
        end
    endtask

    task automatic test_bars_pat3();
        play(3, 0, 3, "bars_pat3");
    endtask

    task automatic test_run_drop();
        logic [7:0] f_before;
        f_before = m_frm;
        play(1, 1, 1, "run_drop");
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if ({out_blank, out_hsync, out_vsync, frame_start, frm_cnt}
                !== {1'b1, 1'b0, 1'b0, 1'b0, f_before + 8'd1}) begin
                n_fail++;
                $display("FAIL run_drop_idle: got blank=%b hs=%b vs=%b fs=%b frm=%h, want 1 0 0 0 %h",
                         out_blank, out_hsync, out_vsync, frame_start, frm_cnt, f_before + 8'd1);
            end
        end
        // Restart after a long idle: the next frame_start is again 2 cycles out.
        play(1, 2, 2, "restart");
    endtask

    task automatic test_async_reset();
        pat = 2'd1;
        run = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (out_blank !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_rst_active: got blank=%b want 0", out_blank);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_blank, out_hsync, out_vsync, out_red, out_green, out_blue, frame_start, frm_cnt, n_hsync, n_vsync}
            !== {1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 8'h00, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL async_rst_immediate: got blank=%b hs=%b vs=%b rgb=%h%h%h fs=%b frm=%h, want 1 0 0 000000 0 00",
                     out_blank, out_hsync, out_vsync, out_red, out_green, out_blue, frame_start, frm_cnt);
        end
        run = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if ({frame_start, out_blank, frm_cnt} !== {1'b0, 1'b1, 8'h00}) begin
                n_fail++;
                $display("FAIL async_rst_hold: got fs=%b blank=%b frm=%h want 0 1 00",
                         frame_start, out_blank, frm_cnt);
            end
        end
        rst   = 1'b0;
        m_frm = 8'h00;
        @(negedge clk);
        play(1, 3, 3, "after_rst");
    endtask

    task automatic test_frm_wrap();
        int nfr;
        nfr = 256 - int'(m_frm);
        play(nfr, 3, 3, "wrap");
        n_checks++;
        if (frm_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL frm_wrap: got frm_cnt=%h want 00", frm_cnt);
        end
        play(1, 3, 3, "wrap_zero");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_sync();
        test_bars_pat3();
        test_run_drop();
        test_async_reset();
        test_frm_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
